// File: rtl/credit_sequencer.sv
// Credit sequencer: conditions coin/button inputs, accumulates saturating credit,
// gates a three-phase timed service cycle on sufficient credit and reports the
// phase as a 3-bit state code.
// Optional feature macro: CREDIT_SEQ_DEBOUNCE_EN (debounced advance button).
module credit_sequencer #(
  parameter int unsigned CREDIT_W        = 8,
  parameter int unsigned PRICE           = 5,
  parameter int unsigned PHASE_CYCLES    = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_in,
  input  logic [3:0]          coin_value,
  input  logic                btn_avance,
  input  logic                btn_cancel,
  output logic [2:0]          estado,
  output logic                avance,
  output logic                hay_credito,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                done,
  output logic                refund
);

  localparam int unsigned WideW  = CREDIT_W + 1;
  localparam int unsigned TimerW = $clog2(PHASE_CYCLES) + 1;
  localparam logic [WideW-1:0]  CreditMax = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [WideW-1:0]  PriceW    = WideW'(PRICE);
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(PHASE_CYCLES - 1);

  if (PRICE < 1 || PRICE > (2 ** CREDIT_W) - 1) begin : gen_bad_price
    $error("credit_sequencer: PRICE out of range");
  end
  if (PHASE_CYCLES < 1) begin : gen_bad_phase
    $error("credit_sequencer: PHASE_CYCLES must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : gen_bad_debounce
    $error("credit_sequencer: DEBOUNCE_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCredit = 3'd1,
    StReady  = 3'd2,
    StRun1   = 3'd3,
    StRun2   = 3'd4,
    StRun3   = 3'd5,
    StDone   = 3'd6
  } state_e;

  // Reset synchronizer: assert asynchronously, release two edges after rst_n rises.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_ok;
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_ok     = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  // Input synchronizers ({cancel, avance, coin}) and edge history for coin/cancel.
  logic [2:0] meta_q, meta_d, sync_q, sync_d;
  logic [1:0] prev_q, prev_d;
  logic       coin_ev, cancel_ev, avance_ev;

  assign meta_d    = rst_ok ? {btn_cancel, btn_avance, coin_in} : 3'b000;
  assign sync_d    = rst_ok ? meta_q : 3'b000;
  assign prev_d    = rst_ok ? {sync_q[2], sync_q[0]} : 2'b00;
  assign coin_ev   = sync_q[0] & ~prev_q[0];
  assign cancel_ev = sync_q[2] & ~prev_q[1];

  // Synchronizer and edge-detector registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

`ifdef CREDIT_SEQ_DEBOUNCE_EN
  localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYCLES - 1);

  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
  logic            deb_armed_q, deb_armed_d, deb_ev_q, deb_ev_d;

  // Armed: count consecutive highs to fire once; disarmed: count consecutive lows to re-arm.
  always_comb begin
    deb_cnt_d   = '0;
    deb_armed_d = deb_armed_q;
    deb_ev_d    = 1'b0;
    if (deb_armed_q) begin
      if (sync_q[1]) begin
        if (deb_cnt_q == DebLast) begin
          deb_ev_d    = 1'b1;
          deb_armed_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
    end else if (!sync_q[1]) begin
      if (deb_cnt_q == DebLast) deb_armed_d = 1'b1;
      else                      deb_cnt_d   = deb_cnt_q + 1'b1;
    end
    if (!rst_ok) begin
      deb_cnt_d   = '0;
      deb_armed_d = 1'b1;
      deb_ev_d    = 1'b0;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q   <= '0;
      deb_armed_q <= 1'b1;
      deb_ev_q    <= 1'b0;
    end else begin
      deb_cnt_q   <= deb_cnt_d;
      deb_armed_q <= deb_armed_d;
      deb_ev_q    <= deb_ev_d;
    end
  end

  assign avance_ev = deb_ev_q;
`else
  logic av_prev_q, av_prev_d;
  assign av_prev_d = rst_ok & sync_q[1];
  assign avance_ev = sync_q[1] & ~av_prev_q;

  // Advance edge-history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) av_prev_q <= 1'b0;
    else        av_prev_q <= av_prev_d;
  end
`endif

  function automatic state_e classify(input logic [CREDIT_W-1:0] c);
    if (c == '0)                  return StIdle;
    else if ({1'b0, c} < PriceW)  return StCredit;
    else                          return StReady;
  endfunction

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [WideW-1:0]    sum;
  logic                in_run, start, do_cancel;
  logic                avance_q, avance_d, hay_q, hay_d, done_q, done_d, refund_q, refund_d;

  assign in_run = (state_q == StRun1) || (state_q == StRun2) || (state_q == StRun3);

  // Credit arithmetic, next state, phase timer and registered output pulses.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    do_cancel = cancel_ev && !in_run;
    start     = (state_q == StReady) && avance_ev && !cancel_ev;
    sum       = {1'b0, credit_q} + (coin_ev ? WideW'(coin_value) : '0) - (start ? PriceW : '0);
    credit_d  = (sum > CreditMax) ? {CREDIT_W{1'b1}} : sum[CREDIT_W-1:0];
    refund_d  = do_cancel && (credit_q != '0);
    if (do_cancel) credit_d = '0;

    case (state_q)
      StIdle, StCredit, StReady: begin
        if (start) begin
          state_d = StRun1;
          timer_d = TimerLoad;
        end else begin
          state_d = classify(credit_d);
        end
      end
      StRun1, StRun2, StRun3: begin
        if (timer_q == '0) begin
          timer_d = TimerLoad;
          state_d = (state_q == StRun1) ? StRun2 : (state_q == StRun2) ? StRun3 : StDone;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StDone: if (avance_ev) state_d = classify(credit_d);
      default: state_d = StIdle;
    endcase
    if (do_cancel) state_d = StIdle;

    avance_d = (state_d != state_q);
    done_d   = (state_d == StDone) && (state_q != StDone);
    hay_d    = (credit_d != '0);

    if (!rst_ok) begin
      state_d  = StIdle;
      timer_d  = '0;
      credit_d = '0;
      avance_d = 1'b0;
      done_d   = 1'b0;
      hay_d    = 1'b0;
      refund_d = 1'b0;
    end
  end

  // Main state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      credit_q <= '0;
      avance_q <= 1'b0;
      done_q   <= 1'b0;
      hay_q    <= 1'b0;
      refund_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      credit_q <= credit_d;
      avance_q <= avance_d;
      done_q   <= done_d;
      hay_q    <= hay_d;
      refund_q <= refund_d;
    end
  end

  assign estado      = state_q;
  assign avance      = avance_q;
  assign hay_credito = hay_q;
  assign credit      = credit_q;
  assign busy        = in_run;
  assign done        = done_q;
  assign refund      = refund_q;

endmodule

// File: tb/tb_credit_sequencer.sv
// Self-checking bench for credit_sequencer: table of coin/cancel vectors through a
// scoreboard queue, plus hand-written service-cycle, simultaneity, bounce and reset
// sequences. Expectations follow CREDIT_SEQ_DEBOUNCE_EN if it is defined.
`timescale 1ns/1ps
module tb_credit_sequencer;

  localparam int unsigned CreditW = 8;
  localparam int unsigned Price   = 5;
  localparam int unsigned Phase   = 4;
  localparam int unsigned Deb     = 4;
`ifdef CREDIT_SEQ_DEBOUNCE_EN
  localparam int DebLat = Deb;
`else
  localparam int DebLat = 0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               coin_in = 1'b0;
  logic [3:0]         coin_value = 4'd0;
  logic               btn_avance = 1'b0;
  logic               btn_cancel = 1'b0;
  logic [2:0]         estado;
  logic               avance, hay_credito, busy, done, refund;
  logic [CreditW-1:0] credit;

  credit_sequencer #(
    .CREDIT_W       (CreditW),
    .PRICE          (Price),
    .PHASE_CYCLES   (Phase),
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coin_in    (coin_in),
    .coin_value (coin_value),
    .btn_avance (btn_avance),
    .btn_cancel (btn_cancel),
    .estado     (estado),
    .avance     (avance),
    .hay_credito(hay_credito),
    .credit     (credit),
    .busy       (busy),
    .done       (done),
    .refund     (refund)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         coin;
    logic [3:0] val;
    bit         cancel;
    int         credit;
    int         estado;
    int         hay;
    int         refund;
  } vec_t;

  typedef struct {
    string name;
    int    credit;
    int    estado;
    int    hay;
    int    refund;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string n, input bit c, input int v, input bit x,
                              input int cr, input int st, input int hy, input int rf);
    vec_t r;
    r.name = n; r.coin = c; r.val = 4'(v); r.cancel = x;
    r.credit = cr; r.estado = st; r.hay = hy; r.refund = rf;
    return r;
  endfunction

  // Drive one coin/cancel pulse, then compare on the third edge after it rises.
  task automatic apply_vec(input vec_t v);
    exp_t e;
    coin_value = v.val;
    coin_in    = v.coin;
    btn_cancel = v.cancel;
    e.name = v.name; e.credit = v.credit; e.estado = v.estado;
    e.hay = v.hay; e.refund = v.refund;
    sb.push_back(e);
    tick(2);
    coin_in    = 1'b0;
    btn_cancel = 1'b0;
    tick(1);
    e = sb.pop_front();
    check({e.name, "/credit"}, 32'(credit), e.credit);
    check({e.name, "/estado"}, 32'(estado), e.estado);
    check({e.name, "/hay_credito"}, 32'(hay_credito), e.hay);
    check({e.name, "/refund"}, 32'(refund), e.refund);
    tick(2);
  endtask

  // From DONE, press advance and check where the state machine lands.
  task automatic leave_done(input string name, input int exp_st);
    int k;
    k = 0;
    while (estado != 3'd6 && k < 40) begin
      tick(1);
      k++;
    end
    check({name, "/in_done"}, 32'(estado), 6);
    btn_avance = 1'b1;
    k = 0;
    while (estado == 3'd6 && k < 30) begin
      tick(1);
      k++;
      if (k == 10) btn_avance = 1'b0;
    end
    btn_avance = 1'b0;
    check({name, "/exit_done"}, 32'(estado), exp_st);
    tick(Deb + 4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    int   dur[8];
    int   t3, av_n, done_n, busy_n, rf_n, done_c, first_done, cancel_c, first_run, k, model, v;
    bit   cancel_sent, saw_run;

    tbl[0]  = mk("coin3",        1, 3,  0, 3,   1, 1, 0);
    tbl[1]  = mk("coin2",        1, 2,  0, 5,   2, 1, 0);
    tbl[2]  = mk("coin_cancel",  1, 7,  1, 0,   0, 0, 1);
    tbl[3]  = mk("cancel_empty", 0, 0,  1, 0,   0, 0, 0);
    tbl[4]  = mk("coin15",       1, 15, 0, 15,  2, 1, 0);
    tbl[5]  = mk("coin1",        1, 1,  0, 16,  2, 1, 0);
    tbl[6]  = mk("sat15",        1, 15, 0, 255, 2, 1, 0);
    tbl[7]  = mk("sat_again",    1, 15, 0, 255, 2, 1, 0);
    tbl[8]  = mk("cancel_full",  0, 0,  1, 0,   0, 0, 1);
    tbl[9]  = mk("coin4",        1, 4,  0, 4,   1, 1, 0);
    tbl[10] = mk("coin1_ready",  1, 1,  0, 5,   2, 1, 0);

    // Reset state
    tick(2);
    check("rst/estado", 32'(estado), 0);
    check("rst/credit", 32'(credit), 0);
    check("rst/hay_credito", 32'(hay_credito), 0);
    check("rst/avance", 32'(avance), 0);
    check("rst/busy", 32'(busy), 0);
    check("rst/done", 32'(done), 0);
    check("rst/refund", 32'(refund), 0);
    rst_n = 1'b1;
    tick(4);

    // Table vectors; fill to 250 before the saturation entries
    for (int i = 0; i < 11; i++) begin
      if (i == 6) begin
        model = 16;
        while (model < 250) begin
          v = (250 - model > 15) ? 15 : 250 - model;
          model += v;
          apply_vec(mk("fill", 1, v, 0, model, 2, 1, 0));
        end
      end
      apply_vec(tbl[i]);
    end

    // Full service cycle from credit 5, with a cancel pulse during RUN2
    foreach (dur[i]) dur[i] = 0;
    t3 = -1; av_n = 0; done_n = 0; busy_n = 0; rf_n = 0; done_c = -1; first_done = -1;
    cancel_sent = 1'b0; cancel_c = 0;
    btn_avance = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick(1);
      if (c == 10) btn_avance = 1'b0;
      if (cancel_sent && c == cancel_c + 2) btn_cancel = 1'b0;
      dur[estado]++;
      if (estado == 3'd3 && t3 < 0) t3 = c;
      if (estado == 3'd6 && first_done < 0) first_done = c;
      if (estado == 3'd4 && !cancel_sent) begin
        btn_cancel  = 1'b1;
        cancel_sent = 1'b1;
        cancel_c    = c;
      end
      if (done) begin
        done_n++;
        done_c = c;
      end
      av_n   += int'(avance);
      busy_n += int'(busy);
      rf_n   += int'(refund);
    end
    btn_cancel = 1'b0;
    check("run/start_latency", 32'(t3), 32'(3 + DebLat));
    check("run/run1_cycles", 32'(dur[3]), Phase);
    check("run/run2_cycles", 32'(dur[4]), Phase);
    check("run/run3_cycles", 32'(dur[5]), Phase);
    check("run/busy_cycles", 32'(busy_n), 3 * Phase);
    check("run/done_pulses", 32'(done_n), 1);
    check("run/done_first_cycle", 32'(done_c), 32'(first_done));
    check("run/avance_pulses", 32'(av_n), 4);
    check("run/no_refund", 32'(rf_n), 0);
    check("run/credit_after", 32'(credit), 0);
    check("run/estado_done", 32'(estado), 6);
    leave_done("run", 0);

    // Advance and cancel together in READY: cancel wins
    apply_vec(mk("sim_setup", 1, 5, 0, 5, 2, 1, 0));
    saw_run = 1'b0; rf_n = 0;
    btn_avance = 1'b1;
    btn_cancel = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (c == 2)  btn_cancel = 1'b0;
      if (c == 10) btn_avance = 1'b0;
      if (estado >= 3'd3 && estado <= 3'd6) saw_run = 1'b1;
      rf_n += int'(refund);
    end
    check("sim/no_run", 32'(saw_run), 0);
    check("sim/estado", 32'(estado), 0);
    check("sim/credit", 32'(credit), 0);
    check("sim/refund_pulses", 32'(rf_n), 1);
    tick(Deb + 2);

    // Bouncy advance: high 2, low 1, high 2
    apply_vec(mk("bounce_setup", 1, 5, 0, 5, 2, 1, 0));
    first_run = -1;
    for (int c = 0; c < 20; c++) begin
      btn_avance = (c < 2 || c == 3 || c == 4);
      tick(1);
      if (estado == 3'd3 && first_run < 0) first_run = c;
    end
    btn_avance = 1'b0;
`ifdef CREDIT_SEQ_DEBOUNCE_EN
    check("bounce/no_start", 32'(first_run), 32'(-1));
    check("bounce/estado", 32'(estado), 2);
    check("bounce/credit", 32'(credit), 5);
    apply_vec(mk("bounce_clear", 0, 0, 1, 0, 0, 0, 1));
`else
    check("bounce/start_first_edge", 32'(first_run), 2);
    check("bounce/credit", 32'(credit), 0);
    leave_done("bounce", 0);
`endif

    // Credit 12, start, cancel ignored in RUN2, then reset mid-RUN2
    apply_vec(mk("rst_setup", 1, 12, 0, 12, 2, 1, 0));
    btn_avance = 1'b1;
    k = 0;
    while (estado != 3'd4 && k < 40) begin
      tick(1);
      k++;
      if (k == 10) btn_avance = 1'b0;
    end
    btn_avance = 1'b0;
    check("rst/reach_run2", 32'(estado), 4);
    btn_cancel = 1'b1;
    tick(2);
    btn_cancel = 1'b0;
    tick(1);
    check("run2_cancel/estado", 32'(estado), 4);
    check("run2_cancel/credit", 32'(credit), 7);
    check("run2_cancel/refund", 32'(refund), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst/estado", 32'(estado), 0);
    check("mid_rst/credit", 32'(credit), 0);
    check("mid_rst/busy", 32'(busy), 0);
    check("mid_rst/hay_credito", 32'(hay_credito), 0);
    tick(1);
    rst_n = 1'b1;
    tick(4);
    check("post_rst/estado", 32'(estado), 0);
    check("post_rst/credit", 32'(credit), 0);
    check("post_rst/done", 32'(done), 0);
    apply_vec(mk("post_rst_coin", 1, 3, 0, 3, 1, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
